// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// DEFAULT_MAX_VAL is also the clamp ceiling used by the range calculator.
package bin_to_bcd_seq_pkg;

   localparam int DIGITS          = 4;
   localparam int BCD_W           = 16;
   localparam int DEFAULT_MAX_VAL = 9999;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the range calculator, the converter and the display.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [3:0]       Thousands_Data;
   logic [3:0]       Hundreds_Data;
   logic [3:0]       Tens_Data;
   logic [3:0]       Ones_Data;

   modport master (
      output start, bin,
      input  busy, done, ovf, Thousands_Data, Hundreds_Data, Tens_Data, Ones_Data
   );

   modport slave (
      input  start, bin,
      output busy, done, ovf, Thousands_Data, Hundreds_Data, Tens_Data, Ones_Data
   );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, BIN_W clocks per result.
// Digit outputs only change on the completion edge, so the display never sees partial values.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int BIN_W   = 14,
   parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
   input logic            clk,
   input logic            rst_n,
   bin_to_bcd_seq_if.slave bus
);

   localparam int               WORK_W  = BCD_W + BIN_W;
   localparam int               CNT_W   = $clog2(BIN_W + 1);
   localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

   state_t            state_reg, state_next;
   logic [WORK_W-1:0] work_reg, work_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              sat_reg, sat_next;
   logic [BCD_W-1:0]  digits_reg, digits_next;
   logic              ovf_reg, ovf_next;
   logic              done_reg, done_next;

   logic [BCD_W-1:0]  bcd_corr;
   logic [WORK_W-1:0] work_shift;
   logic              in_sat;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .d (work_reg[BIN_W + 4*gi +: 4]),
            .q (bcd_corr[4*gi +: 4])
         );
      end
   endgenerate

   assign work_shift = {bcd_corr, work_reg[BIN_W-1:0]} << 1;
   assign in_sat     = (bus.bin > MAX_BIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         work_reg   <= '0;
         count_reg  <= '0;
         sat_reg    <= 1'b0;
         digits_reg <= '0;
         ovf_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         work_reg   <= work_next;
         count_reg  <= count_next;
         sat_reg    <= sat_next;
         digits_reg <= digits_next;
         ovf_reg    <= ovf_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      work_next   = work_reg;
      count_next  = count_reg;
      sat_next    = sat_reg;
      digits_next = digits_reg;
      ovf_next    = ovf_reg;
      done_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               sat_next   = in_sat;
               work_next  = {{BCD_W{1'b0}}, (in_sat ? MAX_BIN : bus.bin)};
               count_next = CNT_W'(BIN_W);
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            work_next  = work_shift;
            count_next = count_reg - CNT_W'(1);
            // Final shift: publish the digits straight from the shifter output.
            if (count_reg == CNT_W'(1)) begin
               digits_next = work_shift[WORK_W-1 -: BCD_W];
               ovf_next    = sat_reg;
               done_next   = 1'b1;
               state_next  = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.busy           = (state_reg == S_SHIFT);
   assign bus.done           = done_reg;
   assign bus.ovf            = ovf_reg;
   assign bus.Thousands_Data = digits_reg[15:12];
   assign bus.Hundreds_Data  = digits_reg[11:8];
   assign bus.Tens_Data      = digits_reg[7:4];
   assign bus.Ones_Data      = digits_reg[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of bin_to_bcd_seq against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

   localparam int BIN_W   = 14;
   localparam int MAX_VAL = 9999;
   localparam int LAT     = 14;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int total    = 0;
   int passed   = 0;
   int lat      = 0;
   int done_cnt = 0;
   int conv_cnt = 0;
   int d0;
   logic [15:0] held_digits;
   logic        held_ovf;

   bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

   bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] digits_now();
      return {bus.Thousands_Data, bus.Hundreds_Data, bus.Tens_Data, bus.Ones_Data};
   endfunction

   // Reference: clamp, then split into decimal digits arithmetically.
   function automatic logic [15:0] ref_bcd(input int v);
      int s;
      s = (v > MAX_VAL) ? MAX_VAL : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) done_cnt++;
   endtask

   task automatic kick(input int v);
      bus.start = 1'b1;
      bus.bin   = 14'(v);
      tick();
      bus.start = 1'b0;
      bus.bin   = 14'($urandom);
      lat       = 0;
      conv_cnt++;
   endtask

   task automatic wait_done(input int v);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("latency", lat, LAT);
      check("digits", digits_now(), ref_bcd(v));
      check("ovf", bus.ovf, (v > MAX_VAL));
      check("busy_at_done", bus.busy, 1'b0);
   endtask

   initial begin
      int vals[3];
      int v;
      bus.start = 1'b0;
      bus.bin   = '0;

      // Reset held, then idle with no requests.
      repeat (3) tick();
      check("reset_state", {bus.busy, bus.done, bus.ovf, digits_now()}, 19'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle", {bus.busy, bus.done, bus.ovf, digits_now()}, 19'd0);
      end
      check("idle_no_done", done_cnt, 0);

      // Single conversion, then outputs must hold.
      kick(1234);
      check("busy_after_start", bus.busy, 1'b1);
      wait_done(1234);
      held_digits = digits_now();
      held_ovf    = bus.ovf;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold", {bus.done, bus.ovf, digits_now()}, {1'b0, held_ovf, held_digits});
      end

      // Boundaries.
      kick(0);     wait_done(0);
      kick(9999);  wait_done(9999);
      kick(10000); wait_done(10000);
      kick(16383); wait_done(16383);

      // A start during SHIFT is ignored and produces no extra done.
      kick(500);
      repeat (4) tick();
      bus.start = 1'b1;
      bus.bin   = 14'd77;
      tick();
      bus.start = 1'b0;
      wait_done(500);
      d0 = done_cnt;
      repeat (30) tick();
      check("no_extra_done", done_cnt, d0);

      // Back-to-back: start in the done cycle.
      kick(3000); wait_done(3000);
      kick(42);   wait_done(42);

      // Start held high: continuous conversions.
      vals[0] = 111; vals[1] = 2222; vals[2] = 12000;
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.bin = 14'(vals[i]);
         tick();
         lat = 0;
         conv_cnt++;
         bus.bin = 14'($urandom);
         wait_done(vals[i]);
      end
      bus.start = 1'b0;

      // Reset in the middle of a conversion discards the result.
      kick(8765);
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      check("mid_reset", {bus.busy, bus.done, bus.ovf, digits_now()}, 19'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      d0 = done_cnt;
      conv_cnt--;
      repeat (30) tick();
      check("post_reset_no_done", done_cnt, d0);
      check("post_reset_state", {bus.busy, bus.ovf, digits_now()}, 18'd0);
      kick(8765); wait_done(8765);

      // Randomized back-to-back sweep.
      for (int i = 0; i < 1500; i++) begin
         v = (i % 4 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
         kick(v);
         wait_done(v);
      end
      tick();
      check("done_count", done_cnt, conv_cnt);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
